// File: rtl/cfs_tx_fifo_if.sv
// Push/pop handshake bundle for the TX FIFO.
// Master drives pushes and consumes pops; slave is the FIFO.
interface cfs_tx_fifo_if #(
    parameter int FIFO_DATA_WIDTH = 37
);
    logic                       push_valid;
    logic [FIFO_DATA_WIDTH-1:0] push_data;
    logic                       push_ready;
    logic                       pop_valid;
    logic [FIFO_DATA_WIDTH-1:0] pop_data;
    logic                       pop_ready;

    modport master (
        output push_valid, push_data, pop_ready,
        input  push_ready, pop_valid, pop_data
    );

    modport slave (
        input  push_valid, push_data, pop_ready,
        output push_ready, pop_valid, pop_data
    );
endinterface

// File: rtl/cfs_tx_fifo.sv
// TX FIFO between aligner core and TX controller.
// First-word-fall-through head, level and full/empty status.
module cfs_tx_fifo #(
    parameter int ALGN_DATA_WIDTH = 32,
    parameter int FIFO_DEPTH      = 8,
    localparam int ALGN_OFFSET_WIDTH =
        (ALGN_DATA_WIDTH <= 8) ? 1 : $clog2(ALGN_DATA_WIDTH / 8),
    localparam int ALGN_SIZE_WIDTH = $clog2(ALGN_DATA_WIDTH / 8) + 1,
    localparam int FIFO_DATA_WIDTH =
        ALGN_DATA_WIDTH + ALGN_OFFSET_WIDTH + ALGN_SIZE_WIDTH,
    localparam int LVL_WIDTH = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    cfs_tx_fifo_if.slave         bus,
    output logic [LVL_WIDTH-1:0] fifo_lvl,
    output logic                 fifo_full,
    output logic                 fifo_empty
);
    localparam int PTR_WIDTH = $clog2(FIFO_DEPTH);
    localparam logic [PTR_WIDTH-1:0] PTR_LAST = PTR_WIDTH'(FIFO_DEPTH - 1);
    localparam logic [LVL_WIDTH-1:0] LVL_MAX  = LVL_WIDTH'(FIFO_DEPTH);

    logic [FIFO_DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_WIDTH-1:0]       wr_ptr;
    logic [PTR_WIDTH-1:0]       rd_ptr;
    logic [LVL_WIDTH-1:0]       lvl;
    logic                       push_fire;
    logic                       pop_fire;

    // Handshake decode purely from registered level.
    always_comb begin
        bus.push_ready = (lvl != LVL_MAX);
        bus.pop_valid  = (lvl != '0);
        bus.pop_data   = bus.pop_valid ? mem[rd_ptr] : '0;
        push_fire      = bus.push_valid & bus.push_ready & ~reset;
        pop_fire       = bus.pop_valid & bus.pop_ready & ~reset;
        fifo_lvl       = lvl;
        fifo_full      = (lvl == LVL_MAX);
        fifo_empty     = (lvl == '0);
    end

    // Storage array; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (push_fire) begin
            mem[wr_ptr] <= bus.push_data;
        end
    end

    // Pointers wrap explicitly so non-power-of-2 depths work.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_fire) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (pop_fire) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
            end
        end
    end

    // Level counter; simultaneous push and pop leave it unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            lvl <= '0;
        end else begin
            unique case ({push_fire, pop_fire})
                2'b10:   lvl <= lvl + 1'b1;
                2'b01:   lvl <= lvl - 1'b1;
                default: lvl <= lvl;
            endcase
        end
    end

    // Level must never leave 0..FIFO_DEPTH and the head must be defined.
    a_lvl_range: assert property (
        @(posedge clk) disable iff (reset) lvl <= LVL_MAX);
    a_no_underflow: assert property (
        @(posedge clk) disable iff (reset) !(lvl == '0 && pop_fire));
    a_head_known: assert property (
        @(posedge clk) disable iff (reset)
        bus.pop_valid |-> !$isunknown(bus.pop_data));
endmodule

// File: tb/tb_cfs_tx_fifo.sv
// Directed bench for cfs_tx_fifo: depth-8 and depth-5 instances.
// Inputs driven and outputs sampled 1ns after each rising edge.
module tb_cfs_tx_fifo;
    localparam int DW = 37;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    logic [3:0] lvl8;
    logic       full8, empty8;
    logic [3:0] lvl5;
    logic       full5, empty5;

    cfs_tx_fifo_if #(.FIFO_DATA_WIDTH(DW)) i8 ();
    cfs_tx_fifo_if #(.FIFO_DATA_WIDTH(DW)) i5 ();

    cfs_tx_fifo #(.ALGN_DATA_WIDTH(32), .FIFO_DEPTH(8)) dut8 (
        .clk       (clk),
        .reset     (reset),
        .bus       (i8),
        .fifo_lvl  (lvl8),
        .fifo_full (full8),
        .fifo_empty(empty8)
    );

    cfs_tx_fifo #(.ALGN_DATA_WIDTH(32), .FIFO_DEPTH(5)) dut5 (
        .clk       (clk),
        .reset     (reset),
        .bus       (i5),
        .fifo_lvl  (lvl5),
        .fifo_full (full5),
        .fifo_empty(empty5)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset         = 1'b1;
        i8.push_valid = 1'b0;
        i8.push_data  = '0;
        i8.pop_ready  = 1'b0;
        i5.push_valid = 1'b0;
        i5.push_data  = '0;
        i5.pop_ready  = 1'b0;
        step();
        step();
        reset = 1'b0;
        step();

        chk("rst_empty", empty8, 1);
        chk("rst_lvl", lvl8, 0);
        chk("rst_full", full8, 0);
        chk("rst_push_ready", i8.push_ready, 1);
        chk("rst_pop_valid", i8.pop_valid, 0);
        chk("rst_pop_data", i8.pop_data, 0);
        chk("rst5_empty", empty5, 1);

        i8.push_valid = 1'b1;
        i8.push_data  = 37'h0A;
        step();
        chk("lat_pop_valid", i8.pop_valid, 1);
        chk("lat_pop_data", i8.pop_data, 37'h0A);
        i8.push_data = 37'h0B;
        step();
        i8.push_data = 37'h0C;
        step();
        i8.push_valid = 1'b0;
        chk("abc_lvl", lvl8, 3);
        chk("abc_head", i8.pop_data, 37'h0A);
        step();
        chk("abc_hold", i8.pop_data, 37'h0A);
        i8.pop_ready = 1'b1;
        chk("abc_pop0", i8.pop_data, 37'h0A);
        step();
        chk("abc_pop1", i8.pop_data, 37'h0B);
        step();
        chk("abc_pop2", i8.pop_data, 37'h0C);
        step();
        chk("abc_lvl_end", lvl8, 0);
        chk("abc_empty", empty8, 1);
        chk("abc_pop_data0", i8.pop_data, 0);
        step();
        chk("empty_pop_lvl", lvl8, 0);
        i8.pop_ready = 1'b0;

        i8.push_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            i8.push_data = 37'h100 + 37'(i);
            step();
        end
        chk("full_flag", full8, 1);
        chk("full_push_ready", i8.push_ready, 0);
        chk("full_lvl", lvl8, 8);
        i8.push_data = 37'h1FF;
        step();
        chk("full_blocked_lvl", lvl8, 8);
        i8.pop_ready = 1'b1;
        chk("full_head", i8.pop_data, 37'h100);
        step();
        i8.pop_ready = 1'b0;
        chk("full_pop_lvl", lvl8, 7);
        chk("full_pop_ready", i8.push_ready, 1);
        step();
        i8.push_valid = 1'b0;
        chk("ninth_lvl", lvl8, 8);
        i8.pop_ready = 1'b1;
        for (int i = 1; i < 8; i++) begin
            chk("full_drain", i8.pop_data, 37'h100 + 37'(i));
            step();
        end
        chk("ninth_word", i8.pop_data, 37'h1FF);
        step();
        i8.pop_ready = 1'b0;
        chk("full_drain_lvl", lvl8, 0);

        i8.push_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            i8.push_data = 37'h200 + 37'(i);
            step();
        end
        chk("stream_lvl0", lvl8, 4);
        i8.pop_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            i8.push_data = 37'h204 + 37'(i);
            chk("stream_out", i8.pop_data, 37'h200 + 37'(i));
            step();
            chk("stream_lvl", lvl8, 4);
        end
        i8.push_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("stream_tail", i8.pop_data, 37'h214 + 37'(i));
            step();
        end
        i8.pop_ready = 1'b0;
        chk("stream_lvl_end", lvl8, 0);

        i8.push_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            i8.push_data = 37'h400 + 37'(i);
            step();
        end
        chk("prerst_lvl", lvl8, 6);
        reset         = 1'b1;
        i8.push_data  = 37'h4AA;
        i8.pop_ready  = 1'b1;
        step();
        reset         = 1'b0;
        i8.push_valid = 1'b0;
        chk("midrst_lvl", lvl8, 0);
        chk("midrst_empty", empty8, 1);
        chk("midrst_pop_valid", i8.pop_valid, 0);
        step();
        i8.pop_ready = 1'b0;
        chk("midrst_lvl_after", lvl8, 0);
        chk("midrst_pop_data", i8.pop_data, 0);

        for (int r = 0; r < 3; r++) begin
            i5.push_valid = 1'b1;
            for (int i = 0; i < 5; i++) begin
                i5.push_data = 37'h300 + 37'(r * 16 + i);
                step();
            end
            i5.push_valid = 1'b0;
            chk("d5_full", full5, 1);
            chk("d5_lvl", lvl5, 5);
            i5.pop_ready = 1'b1;
            for (int i = 0; i < 5; i++) begin
                chk("d5_data", i5.pop_data, 37'h300 + 37'(r * 16 + i));
                step();
            end
            i5.pop_ready = 1'b0;
            chk("d5_empty", empty5, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
